uart_word_assembler: RTL and testbench
======================================

Name: uart_word_assembler

Overview:
Sits directly downstream of the UART receiver.
- Consumes its 8-bit code and one-cycle ready strobe.
- Packs WORD_BYTES consecutive bytes into one little-endian word and buffers complete words in a small FIFO.
- Presents words to the neural-net loader over a valid/ready handshake, so weight/input words arrive at the full UART rate without the consumer servicing every byte.

Parameters:
WORD_BYTES, 2, bytes per output word (1..4)
FIFO_DEPTH, 4, number of complete words buffered (power of two, >=2)
TIMEOUT_CYCLES, 100000, clk cycles without a new byte after which a partial word is discarded (used only with the optional feature)

Ports:
clk  in  1  system clock (100 MHz board clock)
rst  in  1  asynchronous, active-high reset
rx_code  in  8  received byte from the UART receiver
rx_ready  in  1  receiver done strobe; a byte is taken on its rising edge
out_word  out  8*WORD_BYTES  head-of-FIFO word
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts out_word when out_valid && out_ready
level  out  $clog2(FIFO_DEPTH)+1  number of words held
overflow  out  1  sticky; a complete word was dropped because the FIFO was full
clr_overflow  in  1  synchronous clear of overflow

Behaviour:
Reset, asynchronous:
- out_valid=0, level=0, overflow=0, out_word=0.
- Byte counter=0, partial shift register=0, FIFO pointers=0.
- Registered previous rx_ready = 1, so a rx_ready already high when reset deasserts is not counted as a byte.
- Reset mid-word discards the partial word.

Byte accept:
- A byte is accepted in the cycle rx_ready=1 and prev rx_ready=0. rx_code is sampled in that cycle.
- rx_ready held high for many cycles yields exactly one byte.

Assembly:
- The first byte of a word goes to bits [7:0], the k-th byte to bits [8k+7:8k].
- Two-state FSM:
  - IDLE (byte counter = 0) -> COLLECT on accept when WORD_BYTES>1.
  - In COLLECT, the accept of byte WORD_BYTES-1 forms the word from the partial register plus rx_code, issues a push, and returns to IDLE.
  - WORD_BYTES=1: every accept pushes directly.

FIFO:
- Push and pop on the same clk edge.
- Push is permitted if level<FIFO_DEPTH, or if level==FIFO_DEPTH and a pop occurs in the same cycle. Simultaneous push+pop at full keeps level at FIFO_DEPTH.
- A push refused because the FIFO is full:
  - the word is discarded;
  - overflow<=1;
  - the byte counter still returns to 0, so word alignment is preserved.
- If clr_overflow and a new overflow happen in the same cycle, the set wins.
- Pointers wrap modulo FIFO_DEPTH.

Output timing:
- out_valid and out_word are driven from registered state.
- A word pushed at edge N is visible at out_word with out_valid=1 after edge N, i.e. 1-cycle latency from the last byte's accept cycle.
- Pop occurs at an edge where out_valid && out_ready.
- out_ready while empty has no effect.
- out_word is stable while out_valid=1 and out_ready=0.

Optional Feature:
UART_WORD_TIMEOUT_EN:
- Defined:
  - A counter clears on every accept and increments each cycle in COLLECT.
  - When it reaches TIMEOUT_CYCLES with no new byte, the partial word is discarded, the FSM returns to IDLE, and the counter clears.
  - An accept in the same cycle as expiry is treated as the first byte of a new word.
- Undefined:
  - No counter exists.
  - A partial word waits indefinitely for its remaining bytes.

Test Plan:
1. WORD_BYTES=2: strobe 0x34, then 0x12 -> out_word=0x1234 and out_valid=1 one cycle after the 0x12 accept, level=1; pulse out_ready -> level=0, out_valid=0.
2. out_ready=0, send 10 bytes (0x01..0x0A) -> level=4, overflow=1, and the FIFO holds 0x0201, 0x0403, 0x0605, 0x0807. Drain in that order, then pulse clr_overflow -> overflow=0.
3. rx_ready held high 6 cycles with rx_code=0x77, then 0x88 strobed -> exactly one word, 0x8877.
4. Send 0xAA, assert rst for 2 cycles, then send 0x01, 0x02 -> single word 0x0201, no overflow. With rx_ready=1 during reset release -> no byte accepted.
5. FIFO full (4 words), out_ready=1 in the same cycle the next word's last byte is accepted -> pop and push both occur, level stays 4, overflow stays 0.
6. Optional feature, TIMEOUT_CYCLES=1000: send 0x55, idle 1001 cycles, send 0x01, 0x02.
   - Macro defined -> word 0x0201.
   - Macro undefined -> word 0x0155, with 0x02 left pending.

Source files
------------

// File: rtl/uart_word_assembler.sv
// -----------------------------------------------------------------------------
// uart_word_assembler
//
// Packs consecutive bytes from a UART receiver into little-endian words of
// WORD_BYTES bytes and queues complete words in a FIFO_DEPTH-entry FIFO.
// The consumer (neural-net loader) drains words over a valid/ready handshake.
//
// Optional feature macro: UART_WORD_TIMEOUT_EN
//   defined   : a partial word is dropped after TIMEOUT_CYCLES clk cycles
//               with no new byte.
//   undefined : a partial word waits indefinitely for its remaining bytes.
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous, active-high reset
//   rx_code      in   [7:0] received byte
//   rx_ready     in   receiver done strobe; a byte is taken on its rising edge
//   out_word     out  [8*WORD_BYTES-1:0] head-of-FIFO word (registered)
//   out_valid    out  FIFO non-empty (registered)
//   out_ready    in   consumer accepts out_word when out_valid && out_ready
//   level        out  [$clog2(FIFO_DEPTH):0] number of words held
//   overflow     out  sticky flag: a complete word was dropped (FIFO full)
//   clr_overflow in   synchronous clear of overflow (a new drop wins)
// -----------------------------------------------------------------------------
module uart_word_assembler #(
   parameter int WORD_BYTES     = 2,
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [7:0]                      rx_code,
   input  logic                            rx_ready,
   output logic [8*WORD_BYTES-1:0]         out_word,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [$clog2(FIFO_DEPTH):0]     level,
   output logic                            overflow,
   input  logic                            clr_overflow
);

   localparam int WW = 8 * WORD_BYTES;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

   localparam logic [CW-1:0] LAST_IDX = CW'(WORD_BYTES - 1);
   localparam logic [AW:0]   DEPTH_L  = (AW + 1)'(FIFO_DEPTH);

   // Reject illegal configurations at elaboration time.
   if ((WORD_BYTES < 1) || (WORD_BYTES > 4) || (FIFO_DEPTH < 2) ||
       ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (TIMEOUT_CYCLES < 1)) begin : g_bad_param
      $error("uart_word_assembler: illegal parameter combination");
   end

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_COLLECT = 1'b1
   } state_t;

   // Byte capture / assembly
   logic              prev_ready_r;
   logic              accept_s;
   state_t            state_r;
   state_t            state_nxt_s;
   logic [CW-1:0]     byte_cnt_r;
   logic [CW-1:0]     byte_cnt_nxt_s;
   logic [WW-1:0]     partial_r;
   logic [WW-1:0]     partial_nxt_s;
   logic [WW-1:0]     byte_ext_s;
   logic [WW-1:0]     byte_shift_s;
   logic              push_req_s;
   logic [WW-1:0]     push_word_s;
   logic              expire_s;

   // FIFO
   logic [WW-1:0]     mem_r [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_r;
   logic [AW-1:0]     rd_ptr_r;
   logic [AW-1:0]     rd_ptr_nxt_s;
   logic [AW:0]       level_r;
   logic [AW:0]       level_nxt_s;
   logic [AW:0]       remain_s;
   logic              pop_s;
   logic              push_ok_s;
   logic              drop_s;
   logic [WW-1:0]     out_word_r;
   logic [WW-1:0]     head_nxt_s;
   logic              out_valid_r;
   logic              overflow_r;

   // A byte is taken only on a rising edge of rx_ready.
   assign accept_s = rx_ready & ~prev_ready_r;

   // Previous rx_ready; resets high so a strobe already high at reset release is ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_ready_r <= 1'b1;
      end else begin
         prev_ready_r <= rx_ready;
      end
   end

`ifdef UART_WORD_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);

   logic [TMO_W-1:0] tmo_cnt_r;

   assign expire_s = (state_r == ST_COLLECT) && (tmo_cnt_r == TMO_MAX);

   // Inactivity counter: runs only while a partial word is held.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt_r <= {TMO_W{1'b0}};
      end else if ((state_r == ST_IDLE) || accept_s || expire_s) begin
         tmo_cnt_r <= {TMO_W{1'b0}};
      end else begin
         tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
      end
   end
`else
   assign expire_s = 1'b0;
`endif

   // Assembly FSM next-state: builds the partial word and requests pushes.
   always_comb begin
      state_nxt_s    = state_r;
      byte_cnt_nxt_s = byte_cnt_r;
      partial_nxt_s  = partial_r;
      push_req_s     = 1'b0;
      push_word_s    = {WW{1'b0}};
      byte_ext_s     = WW'(rx_code);
      byte_shift_s   = byte_ext_s << {byte_cnt_r, 3'b000};

      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               if (WORD_BYTES == 1) begin
                  push_req_s  = 1'b1;
                  push_word_s = byte_ext_s;
               end else begin
                  state_nxt_s    = ST_COLLECT;
                  byte_cnt_nxt_s = CW'(1);
                  partial_nxt_s  = byte_ext_s;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_COLLECT: begin
            if (accept_s && expire_s) begin
               // Stale partial word is dropped; this byte starts a new word.
               state_nxt_s    = ST_COLLECT;
               byte_cnt_nxt_s = CW'(1);
               partial_nxt_s  = byte_ext_s;
            end else if (expire_s) begin
               state_nxt_s    = ST_IDLE;
               byte_cnt_nxt_s = {CW{1'b0}};
               partial_nxt_s  = {WW{1'b0}};
            end else if (accept_s) begin
               if (byte_cnt_r == LAST_IDX) begin
                  // Last byte: push regardless of FIFO space so alignment holds.
                  push_req_s     = 1'b1;
                  push_word_s    = partial_r | byte_shift_s;
                  state_nxt_s    = ST_IDLE;
                  byte_cnt_nxt_s = {CW{1'b0}};
                  partial_nxt_s  = {WW{1'b0}};
               end else begin
                  partial_nxt_s  = partial_r | byte_shift_s;
                  byte_cnt_nxt_s = byte_cnt_r + CW'(1);
               end
            end else begin
               state_nxt_s = ST_COLLECT;
            end
         end
         default: begin
            state_nxt_s    = ST_IDLE;
            byte_cnt_nxt_s = {CW{1'b0}};
            partial_nxt_s  = {WW{1'b0}};
         end
      endcase
   end

   // Assembly FSM state, byte counter and partial word registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         byte_cnt_r <= {CW{1'b0}};
         partial_r  <= {WW{1'b0}};
      end else begin
         state_r    <= state_nxt_s;
         byte_cnt_r <= byte_cnt_nxt_s;
         partial_r  <= partial_nxt_s;
      end
   end

   // FIFO control: push/pop arbitration and the next registered head word.
   always_comb begin
      pop_s        = out_valid_r & out_ready;
      push_ok_s    = push_req_s & ((level_r != DEPTH_L) | pop_s);
      drop_s       = push_req_s & ~push_ok_s;
      rd_ptr_nxt_s = pop_s ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
      remain_s     = pop_s ? (level_r - (AW + 1)'(1)) : level_r;

      case ({push_ok_s, pop_s})
         2'b10:   level_nxt_s = level_r + (AW + 1)'(1);
         2'b01:   level_nxt_s = level_r - (AW + 1)'(1);
         default: level_nxt_s = level_r;
      endcase

      // When full, the write slot equals the popped slot, never rd_ptr_nxt_s,
      // so reading the current array for the surviving head is safe.
      if (remain_s != {(AW + 1){1'b0}}) begin
         head_nxt_s = mem_r[rd_ptr_nxt_s];
      end else if (push_ok_s) begin
         head_nxt_s = push_word_s;
      end else begin
         head_nxt_s = out_word_r;
      end
   end

   // FIFO storage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_r[i] <= {WW{1'b0}};
         end
      end else if (push_ok_s) begin
         mem_r[wr_ptr_r] <= push_word_s;
      end else begin
         mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
      end
   end

   // FIFO pointers, level and registered head outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r    <= {AW{1'b0}};
         rd_ptr_r    <= {AW{1'b0}};
         level_r     <= {(AW + 1){1'b0}};
         out_word_r  <= {WW{1'b0}};
         out_valid_r <= 1'b0;
      end else begin
         wr_ptr_r    <= push_ok_s ? (wr_ptr_r + AW'(1)) : wr_ptr_r;
         rd_ptr_r    <= rd_ptr_nxt_s;
         level_r     <= level_nxt_s;
         out_word_r  <= head_nxt_s;
         out_valid_r <= (level_nxt_s != {(AW + 1){1'b0}});
      end
   end

   // Sticky overflow flag; a new drop takes priority over the clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_r <= 1'b0;
      end else if (drop_s) begin
         overflow_r <= 1'b1;
      end else if (clr_overflow) begin
         overflow_r <= 1'b0;
      end else begin
         overflow_r <= overflow_r;
      end
   end

   assign out_word  = out_word_r;
   assign out_valid = out_valid_r;
   assign level     = level_r;
   assign overflow  = overflow_r;

endmodule

// File: tb/tb_uart_word_assembler.sv
// -----------------------------------------------------------------------------
// tb_uart_word_assembler
//
// Directed self-checking bench for uart_word_assembler (WORD_BYTES=2,
// FIFO_DEPTH=4, TIMEOUT_CYCLES=1000). Inputs change 1 time unit after the
// rising clock edge and outputs are sampled there too, away from the edge.
// Expected words are hand-computed little-endian packings of the bytes sent.
// -----------------------------------------------------------------------------
module tb_uart_word_assembler;

   logic        clk;
   logic        rst;
   logic [7:0]  rx_code;
   logic        rx_ready;
   logic [15:0] out_word;
   logic        out_valid;
   logic        out_ready;
   logic [2:0]  level;
   logic        overflow;
   logic        clr_overflow;

   int tests_run    = 0;
   int tests_failed = 0;

   uart_word_assembler #(
      .WORD_BYTES     (2),
      .FIFO_DEPTH     (4),
      .TIMEOUT_CYCLES (1000)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .rx_code      (rx_code),
      .rx_ready     (rx_ready),
      .out_word     (out_word),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .level        (level),
      .overflow     (overflow),
      .clr_overflow (clr_overflow)
   );

   // 100 MHz clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_code  = b;
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
      tick();
   endtask

   task automatic pop_word();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic expect_pop(input string tag, input logic [15:0] exp);
      check_value({tag, "_valid"}, 32'(out_valid), 32'd1);
      check_value({tag, "_word"}, 32'(out_word), 32'(exp));
      pop_word();
   endtask

   initial begin
      rst          = 1'b1;
      rx_code      = 8'h00;
      rx_ready     = 1'b0;
      out_ready    = 1'b0;
      clr_overflow = 1'b0;
      tick();
      tick();
      check_value("rst_valid",    32'(out_valid), 32'd0);
      check_value("rst_level",    32'(level),     32'd0);
      check_value("rst_overflow", 32'(overflow),  32'd0);
      check_value("rst_word",     32'(out_word),  32'd0);
      rst = 1'b0;
      tick();

      // 1: basic pairing and one-cycle latency from the last accept
      send_byte(8'h34);
      check_value("t1_half_valid", 32'(out_valid), 32'd0);
      rx_code  = 8'h12;
      rx_ready = 1'b1;
      tick();
      check_value("t1_valid", 32'(out_valid), 32'd1);
      check_value("t1_word",  32'(out_word),  32'h1234);
      check_value("t1_level", 32'(level),     32'd1);
      rx_ready = 1'b0;
      tick();
      pop_word();
      check_value("t1_pop_level", 32'(level),     32'd0);
      check_value("t1_pop_valid", 32'(out_valid), 32'd0);
      // out_ready while empty does nothing
      pop_word();
      check_value("t1_empty_pop_level", 32'(level), 32'd0);

      // 2: overflow with consumer stalled
      for (int i = 1; i <= 10; i++) begin
         send_byte(8'(i));
      end
      check_value("t2_level",    32'(level),    32'd4);
      check_value("t2_overflow", 32'(overflow), 32'd1);
      tick();
      tick();
      check_value("t2_stable_word", 32'(out_word), 32'h0201);
      expect_pop("t2_w0", 16'h0201);
      expect_pop("t2_w1", 16'h0403);
      expect_pop("t2_w2", 16'h0605);
      expect_pop("t2_w3", 16'h0807);
      check_value("t2_drained_valid", 32'(out_valid), 32'd0);
      check_value("t2_overflow_held", 32'(overflow),  32'd1);
      clr_overflow = 1'b1;
      tick();
      clr_overflow = 1'b0;
      check_value("t2_overflow_clr", 32'(overflow), 32'd0);

      // 3: rx_ready held high gives exactly one byte
      rx_code  = 8'h77;
      rx_ready = 1'b1;
      repeat (6) tick();
      rx_ready = 1'b0;
      tick();
      check_value("t3_no_word_yet", 32'(level), 32'd0);
      send_byte(8'h88);
      check_value("t3_level", 32'(level), 32'd1);
      expect_pop("t3", 16'h8877);
      check_value("t3_after_level", 32'(level), 32'd0);

      // 4a: reset mid-word discards the partial byte
      send_byte(8'hAA);
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
      send_byte(8'h01);
      send_byte(8'h02);
      check_value("t4_level",    32'(level),    32'd1);
      check_value("t4_overflow", 32'(overflow), 32'd0);
      expect_pop("t4", 16'h0201);

      // 4b: rx_ready high across reset release is not a byte
      rx_code  = 8'hEE;
      rx_ready = 1'b1;
      rst      = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      repeat (3) tick();
      rx_ready = 1'b0;
      tick();
      send_byte(8'h03);
      send_byte(8'h04);
      check_value("t4b_level", 32'(level), 32'd1);
      expect_pop("t4b", 16'h0403);

      // 5: push and pop on the same edge while full
      for (int i = 1; i <= 8; i++) begin
         send_byte(8'(i));
      end
      check_value("t5_full_level", 32'(level), 32'd4);
      send_byte(8'h09);
      rx_code   = 8'h0A;
      rx_ready  = 1'b1;
      out_ready = 1'b1;
      tick();
      rx_ready  = 1'b0;
      out_ready = 1'b0;
      check_value("t5_level",    32'(level),    32'd4);
      check_value("t5_overflow", 32'(overflow), 32'd0);
      tick();
      expect_pop("t5_w0", 16'h0403);
      expect_pop("t5_w1", 16'h0605);
      expect_pop("t5_w2", 16'h0807);
      expect_pop("t5_w3", 16'h0A09);
      check_value("t5_drained_valid", 32'(out_valid), 32'd0);

      // 6: partial word across a long idle gap
      send_byte(8'h55);
      repeat (1001) tick();
      send_byte(8'h01);
      send_byte(8'h02);
      check_value("t6_level", 32'(level), 32'd1);
`ifdef UART_WORD_TIMEOUT_EN
      expect_pop("t6_timeout", 16'h0201);
`else
      expect_pop("t6_no_timeout", 16'h0155);
      send_byte(8'h03);
      expect_pop("t6_pending", 16'h0302);
`endif
      check_value("t6_final_level", 32'(level), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
